// File: rtl/pakout_pkg.sv
// Shared sizes, derived widths and FSM encoding for the pakout message-to-packet splitter.
package pakout_pkg;

   localparam int NS_PSZ     = 8;
   localparam int NS_FSZ     = 4;
   localparam int NS_ASZ     = 6;
   localparam int NS_DSZ     = 4;
   localparam int NS_RSZ     = 4;
   localparam int NS_REQ_CKS = 4;
   localparam int NS_ACK_CKS = 4;

   function automatic int msg_size(input int asz, input int dsz, input int rsz);
      return 2*asz + dsz + rsz;
   endfunction

   // One extra packet always exists, so the last packet is partly zero-filled.
   function automatic int tot_pks(input int msz, input int psz);
      return msz/psz + 1;
   endfunction

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      LOAD        = 2'd1,
      WAIT_ACK_HI = 2'd2,
      WAIT_ACK_LO = 2'd3
   } state_t;

endpackage

// File: rtl/pakout_msg_fifo.sv
// Message FIFO: register array with head available combinationally, count-based full/empty.
module pakout_msg_fifo #(
   parameter int W     = 20,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_reg;
   logic [AW-1:0] rd_reg;
   logic [AW:0]   count_reg;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO may still accept.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_reg];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_reg] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_reg    <= '0;
         rd_reg    <= '0;
         count_reg <= '0;
      end else begin
         if (do_push)
            wr_reg <= wr_reg + 1'b1;
         if (do_pop)
            rd_reg <= rd_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/pakout.sv
// Buffers req/ack messages and splits each into MSB-first packets on a req/ack packet channel.
// Optional NS_PAKOUT_MSG_CNT_EN adds a 16-bit count of fully sent messages (msg_cnt).
module pakout
   import pakout_pkg::*;
#(
   parameter int PSZ     = NS_PSZ,
   parameter int FSZ     = NS_FSZ,
   parameter int ASZ     = NS_ASZ,
   parameter int DSZ     = NS_DSZ,
   parameter int RSZ     = NS_RSZ,
   parameter int REQ_CKS = NS_REQ_CKS,
   parameter int ACK_CKS = NS_ACK_CKS
) (
   input  logic           i_clk,
   input  logic           reset,
   output logic           ready,
`ifdef NS_PAKOUT_MSG_CNT_EN
   output logic [15:0]    msg_cnt,
`endif
   input  logic [ASZ-1:0] rcv0_src,
   input  logic [ASZ-1:0] rcv0_dst,
   input  logic [DSZ-1:0] rcv0_dat,
   input  logic [RSZ-1:0] rcv0_red,
   input  logic           rcv0_req,
   output logic           rcv0_ack,
   output logic [PSZ-1:0] snd0_pakio,
   output logic           snd0_req,
   input  logic           snd0_ack
);

   localparam int MSZ     = msg_size(ASZ, DSZ, RSZ);
   localparam int TOT_PKS = tot_pks(MSZ, PSZ);
   localparam int KW      = idx_w(TOT_PKS);
   localparam int PADW    = TOT_PKS * PSZ;
   localparam int CW      = idx_w((REQ_CKS > ACK_CKS) ? REQ_CKS : ACK_CKS);

   logic [1:0]     raw;
   logic [1:0]     filt;
   logic [1:0]     primed;
   logic           init_reg;
   logic           ack_reg;
   state_t         state_reg;
   state_t         state_next;
   logic [KW-1:0]  k_reg;
   logic [MSZ-1:0] msg_reg;
   logic [MSZ-1:0] msg_in;
   logic [MSZ-1:0] fifo_head;
   logic [PADW-1:0] pak_ext;
   logic [PSZ-1:0] pkts [TOT_PKS];
   logic           push;
   logic           pop;
   logic           full;
   logic           empty;
   logic           last_pk;

   // Index 0 filters the message request, index 1 the packet acknowledge.
   assign raw = {snd0_ack, rcv0_req};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_db
         localparam int CKS = (gi == 0) ? REQ_CKS : ACK_CKS;
         logic [CW-1:0] cnt_reg;
         logic [CW-1:0] prime_reg;
         logic          filt_reg;
         logic          primed_reg;

         always_ff @(posedge i_clk or negedge reset) begin
            if (!reset) begin
               cnt_reg    <= '0;
               prime_reg  <= '0;
               filt_reg   <= 1'b0;
               primed_reg <= 1'b0;
            end else begin
               if (raw[gi] == filt_reg)
                  cnt_reg <= '0;
               else if (cnt_reg == CW'(CKS-1)) begin
                  filt_reg <= raw[gi];
                  cnt_reg  <= '0;
               end else
                  cnt_reg <= cnt_reg + 1'b1;
               if (!primed_reg) begin
                  if (prime_reg == CW'(CKS-1))
                     primed_reg <= 1'b1;
                  else
                     prime_reg <= prime_reg + 1'b1;
               end
            end
         end

         assign filt[gi]   = filt_reg;
         assign primed[gi] = primed_reg;
      end

      // Packet gi is a PSZ slice of the message, zero-padded at the LSB end.
      for (gi = 0; gi < TOT_PKS; gi++) begin : g_pk
         assign pkts[gi] = pak_ext[PADW-1-gi*PSZ -: PSZ];
      end
   endgenerate

   assign msg_in   = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
   assign pak_ext  = {msg_reg, {(PADW-MSZ){1'b0}}};
   assign ready    = init_reg & (&primed);
   assign last_pk  = (k_reg == KW'(TOT_PKS-1));
   assign pop      = ready & (state_reg == IDLE) & ~empty;
   assign push     = ready & filt[0] & ~ack_reg & (~full | pop);
   assign rcv0_ack = ack_reg;

   pakout_msg_fifo #(
      .W     (MSZ),
      .DEPTH (FSZ)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (reset),
      .push  (push),
      .pop   (pop),
      .din   (msg_in),
      .dout  (fifo_head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         init_reg  <= 1'b0;
         ack_reg   <= 1'b0;
         state_reg <= IDLE;
         k_reg     <= '0;
         msg_reg   <= '0;
      end else begin
         init_reg  <= 1'b1;
         ack_reg   <= push | (filt[0] & ack_reg);
         state_reg <= state_next;
         if (pop) begin
            msg_reg <= fifo_head;
            k_reg   <= '0;
         end else if (state_reg == WAIT_ACK_LO && !filt[1] && !last_pk)
            k_reg <= k_reg + 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:        if (pop) state_next = LOAD;
         LOAD:        state_next = WAIT_ACK_HI;
         WAIT_ACK_HI: if (filt[1]) state_next = WAIT_ACK_LO;
         WAIT_ACK_LO: if (!filt[1]) state_next = last_pk ? IDLE : LOAD;
         default:     state_next = IDLE;
      endcase
   end

   always_comb begin
      snd0_req   = (state_reg == WAIT_ACK_HI);
      snd0_pakio = (state_reg == IDLE) ? '0 : pkts[k_reg];
   end

`ifdef NS_PAKOUT_MSG_CNT_EN
   logic [15:0] msg_cnt_reg;

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset)
         msg_cnt_reg <= '0;
      else if (state_reg == WAIT_ACK_LO && !filt[1] && last_pk)
         msg_cnt_reg <= msg_cnt_reg + 16'd1;
   end

   assign msg_cnt = msg_cnt_reg;
`endif

endmodule

// File: tb/tb_pakout.sv
// Directed, table-driven bench for pakout: message table with hand-computed packets plus corner sequences.
module tb_pakout;

   typedef struct packed {
      logic [5:0]  src;
      logic [5:0]  dst;
      logic [3:0]  dat;
      logic [3:0]  red;
      logic [23:0] pk;
   } vec_t;

   logic       i_clk;
   logic       reset;
   logic       ready;
   logic [5:0] rcv0_src;
   logic [5:0] rcv0_dst;
   logic [3:0] rcv0_dat;
   logic [3:0] rcv0_red;
   logic       rcv0_req;
   logic       rcv0_ack;
   logic [7:0] snd0_pakio;
   logic       snd0_req;
   logic       snd0_ack;
`ifdef NS_PAKOUT_MSG_CNT_EN
   logic [15:0] msg_cnt;
`endif

   int   n_cmp = 0;
   int   n_err = 0;
   int   ack_pulses = 0;
   logic ack_d = 1'b0;
   vec_t vecs [12];

   pakout dut (
      .i_clk      (i_clk),
      .reset      (reset),
      .ready      (ready),
`ifdef NS_PAKOUT_MSG_CNT_EN
      .msg_cnt    (msg_cnt),
`endif
      .rcv0_src   (rcv0_src),
      .rcv0_dst   (rcv0_dst),
      .rcv0_dat   (rcv0_dat),
      .rcv0_red   (rcv0_red),
      .rcv0_req   (rcv0_req),
      .rcv0_ack   (rcv0_ack),
      .snd0_pakio (snd0_pakio),
      .snd0_req   (snd0_req),
      .snd0_ack   (snd0_ack)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) begin
      ack_d <= rcv0_ack;
      if (rcv0_ack && !ack_d)
         ack_pulses <= ack_pulses + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_start(input vec_t v);
      rcv0_src = v.src;
      rcv0_dst = v.dst;
      rcv0_dat = v.dat;
      rcv0_red = v.red;
      rcv0_req = 1'b1;
   endtask

   task automatic wait_rcv_ack(input int budget, output bit ok);
      int n = 0;
      while (!rcv0_ack && n < budget) begin
         @(negedge i_clk);
         n++;
      end
      ok = rcv0_ack;
   endtask

   task automatic send_end();
      int n = 0;
      rcv0_req = 1'b0;
      while (rcv0_ack && n < 100) begin
         @(negedge i_clk);
         n++;
      end
      check("rcv_ack_release", {31'b0, rcv0_ack}, 32'd0);
   endtask

   task automatic send_list(input int first, input int nmsg);
      bit ok;
      for (int m = first; m < first + nmsg; m++) begin
         @(negedge i_clk);
         send_start(vecs[m]);
         wait_rcv_ack(400, ok);
         check("send_accept", {31'b0, ok}, 32'd1);
         send_end();
      end
   endtask

   task automatic recv_pkt(output logic [7:0] p, output bit ok);
      int n = 0;
      p  = 8'h00;
      ok = 1'b0;
      while (!snd0_req && n < 300) begin
         @(negedge i_clk);
         n++;
      end
      if (!snd0_req) return;
      p = snd0_pakio;
      snd0_ack = 1'b1;
      n = 0;
      while (snd0_req && n < 100) begin
         @(negedge i_clk);
         n++;
      end
      snd0_ack = 1'b0;
      ok = !snd0_req;
   endtask

   task automatic collect(input int first, input int nmsg, input string tag);
      logic [7:0] p;
      bit ok;
      for (int m = first; m < first + nmsg; m++) begin
         for (int k = 0; k < 3; k++) begin
            recv_pkt(p, ok);
            check({tag, "_handshake"}, {31'b0, ok}, 32'd1);
            if (!ok) return;
            $display("pkt %s msg=%0d k=%0d data=%02h", tag, m, k, p);
            check(tag, {24'b0, p}, {24'b0, vecs[m].pk[23-8*k -: 8]});
         end
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!ready && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      check(tag, {31'b0, ready}, 32'd1);
   endtask

   initial begin
      bit         ok;
      int         p0;
      int         req_seen;
      logic [7:0] held;

      // Hand-computed: msg={src,dst,dat,red}; packets msg[19:12], msg[11:4], {msg[3:0],4'h0}.
      vecs[0]  = '{6'h2A, 6'h15, 4'h9, 4'h3, 24'hA95930};
      vecs[1]  = '{6'h00, 6'h00, 4'h0, 4'h0, 24'h000000};
      vecs[2]  = '{6'h3F, 6'h3F, 4'hF, 4'hF, 24'hFFFFF0};
      vecs[3]  = '{6'h01, 6'h20, 4'h5, 4'hA, 24'h0605A0};
      vecs[4]  = '{6'h20, 6'h01, 4'hA, 4'h5, 24'h801A50};
      vecs[5]  = '{6'h15, 6'h2A, 4'h6, 4'hC, 24'h56A6C0};
      vecs[6]  = '{6'h12, 6'h34, 4'h7, 4'h1, 24'h4B4710};
      vecs[7]  = '{6'h3C, 6'h03, 4'h8, 4'hE, 24'hF038E0};
      vecs[8]  = '{6'h07, 6'h38, 4'hB, 4'h2, 24'h1F8B20};
      vecs[9]  = '{6'h2D, 6'h1E, 4'h4, 4'hD, 24'hB5E4D0};
      vecs[10] = '{6'h33, 6'h0C, 4'h1, 4'h7, 24'hCCC170};
      vecs[11] = '{6'h0A, 6'h25, 4'hE, 4'h9, 24'h2A5E90};

      reset    = 1'b0;
      rcv0_src = '0;
      rcv0_dst = '0;
      rcv0_dat = '0;
      rcv0_red = '0;
      rcv0_req = 1'b0;
      snd0_ack = 1'b0;

      // Reset state
      repeat (3) @(negedge i_clk);
      check("rst_ready",    {31'b0, ready},    32'd0);
      check("rst_rcv0_ack", {31'b0, rcv0_ack}, 32'd0);
      check("rst_snd0_req", {31'b0, snd0_req}, 32'd0);
      check("rst_pakio",    {24'b0, snd0_pakio}, 32'd0);
`ifdef NS_PAKOUT_MSG_CNT_EN
      check("rst_msg_cnt",  {16'b0, msg_cnt},  32'd0);
`endif
      reset = 1'b1;
      @(negedge i_clk);
      check("ready_not_primed", {31'b0, ready}, 32'd0);
      wait_ready("ready_rise");

      // Single message: three packets in order, one rcv0_ack pulse
      p0 = ack_pulses;
      fork
         send_list(0, 1);
         collect(0, 1, "single");
      join
      repeat (10) @(negedge i_clk);
      check("single_ack_pulses", ack_pulses - p0, 32'd1);

      // Back-pressure: 5 accepted with snd0_ack held low, 6th stalls
      p0 = ack_pulses;
      send_list(2, 5);
      @(negedge i_clk);
      send_start(vecs[7]);
      wait_rcv_ack(40, ok);
      check("bp_sixth_stall", {31'b0, ok}, 32'd0);

      // Short ack glitch must not advance anything
      check("glitch_req_before", {31'b0, snd0_req}, 32'd1);
      held = snd0_pakio;
      check("glitch_pakio_before", {24'b0, held}, 32'h0000_00FF);
      snd0_ack = 1'b1;
      repeat (2) @(negedge i_clk);
      snd0_ack = 1'b0;
      repeat (8) @(negedge i_clk);
      check("glitch_req_after",   {31'b0, snd0_req},   32'd1);
      check("glitch_pakio_after", {24'b0, snd0_pakio}, {24'b0, held});

      fork
         begin
            wait_rcv_ack(600, ok);
            check("bp_sixth_late", {31'b0, ok}, 32'd1);
            send_end();
         end
         collect(2, 6, "bp");
      join
      repeat (10) @(negedge i_clk);
      check("bp_ack_pulses", ack_pulses - p0, 32'd6);

      // Ten messages through a full FIFO: push and pop coincide, pointers wrap
      fork
         send_list(2, 10);
         collect(2, 10, "wrap");
      join
      repeat (10) @(negedge i_clk);

      // Reset between packet 1 and packet 2
      fork
         send_list(0, 1);
         begin
            logic [7:0] p;
            recv_pkt(p, ok);
            check("mid_pkt0", {24'b0, p}, 32'h0000_00A9);
         end
      join
      wait_rcv_ack(0, ok);
      begin
         int n = 0;
         while (!snd0_req && n < 100) begin
            @(negedge i_clk);
            n++;
         end
      end
      check("mid_req_pkt1", {31'b0, snd0_req}, 32'd1);
      check("mid_pakio_pkt1", {24'b0, snd0_pakio}, 32'h0000_0059);
      #2 reset = 1'b0;
      #1;
      check("mid_req_async",   {31'b0, snd0_req},   32'd0);
      check("mid_pakio_async", {24'b0, snd0_pakio}, 32'd0);
      check("mid_ready_async", {31'b0, ready},      32'd0);
      repeat (2) @(negedge i_clk);
      reset = 1'b1;
      wait_ready("mid_ready_again");
      req_seen = 0;
      repeat (60) begin
         @(negedge i_clk);
         if (snd0_req) req_seen++;
      end
      check("mid_no_residual", req_seen, 32'd0);

`ifdef NS_PAKOUT_MSG_CNT_EN
      check("cnt_after_reset", {16'b0, msg_cnt}, 32'd0);
      fork
         send_list(8, 3);
         collect(8, 3, "cnt");
      join
      repeat (10) @(negedge i_clk);
      check("cnt_three", {16'b0, msg_cnt}, 32'd3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
